// File: rtl/mdu_sequencer_if.sv
// Issue/read bundle between the Execute stage and the multiply/divide unit.
interface mdu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_mdu_op;
  logic [WIDTH-1:0] i_srcA;
  logic [WIDTH-1:0] i_srcB;
  logic             i_rd_hilo;
  logic             i_rd_sel;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_busy;
  logic             o_stall;
  logic             o_done;

  modport master (
    output i_start, i_mdu_op, i_srcA, i_srcB, i_rd_hilo, i_rd_sel,
    input  o_rd_data, o_busy, o_stall, o_done
  );

  modport slave (
    input  i_start, i_mdu_op, i_srcA, i_srcB, i_rd_hilo, i_rd_sel,
    output o_rd_data, o_busy, o_stall, o_done
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a final FIX cycle, MTHI/MTLO and MFHI/MFLO.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mdu_sequencer_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   amag_q, amag_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0]   orig_a_q, orig_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               done_q, done_d;

  logic               is_mul_op, is_div_op, is_signed_op;
  logic               sign_a, sign_b;
  logic               idle_start, accept_md;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_rem_sh, div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Two's-complement negate when the flag is set.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    cond_neg2 = neg ? -v : v;
  endfunction

  // Decode the issued op; only IDLE accepts anything.
  always_comb begin
    is_mul_op    = (bus.i_mdu_op == OP_MULT) || (bus.i_mdu_op == OP_MULTU);
    is_div_op    = (bus.i_mdu_op == OP_DIV)  || (bus.i_mdu_op == OP_DIVU);
    is_signed_op = (bus.i_mdu_op == OP_MULT) || (bus.i_mdu_op == OP_DIV);
    sign_a       = is_signed_op & bus.i_srcA[WIDTH-1];
    sign_b       = is_signed_op & bus.i_srcB[WIDTH-1];
    idle_start   = (state_q == S_IDLE) && bus.i_start;
    accept_md    = idle_start && (is_mul_op || is_div_op);
  end

  // One iteration of each loop plus the FIX-cycle sign correction.
  always_comb begin
    // Multiply: acc = {partial, multiplier}; add |A| on multiplier LSB, shift right.
    mul_addend = acc_q[0] ? amag_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_step   = {mul_sum, acc_q[WIDTH-1:1]};
    // Divide: acc = {rem, quot}; shift left, trial-subtract |B|, keep if nonnegative.
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, bmag_q};
    if (div_diff[WIDTH]) begin
      div_step = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    prod_fix = cond_neg2(acc_q, neg_q_q);
    quot_fix = cond_neg(acc_q[WIDTH-1:0], neg_q_q);
    rem_fix  = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_r_q);
  end

  // State register and all datapath flops; reset clears everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      amag_q   <= '0;
      bmag_q   <= '0;
      orig_a_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      amag_q   <= amag_d;
      bmag_q   <= bmag_d;
      orig_a_q <= orig_a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      done_q   <= done_d;
    end
  end

  // Next-state: IDLE -> ITER on MUL/DIV, ITER until count hits 0, FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_md) state_d = S_ITER;
      S_ITER:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates per state; HI/LO change only on MTxx or at FIX.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    amag_d   = amag_q;
    bmag_d   = bmag_q;
    orig_a_d = orig_a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    done_d   = (state_q == S_FIX);
    unique case (state_q)
      S_IDLE: begin
        if (idle_start && (bus.i_mdu_op == OP_MTHI)) hi_d = bus.i_srcA;
        if (idle_start && (bus.i_mdu_op == OP_MTLO)) lo_d = bus.i_srcA;
        if (accept_md) begin
          amag_d   = cond_neg(bus.i_srcA, sign_a);
          bmag_d   = cond_neg(bus.i_srcB, sign_b);
          orig_a_d = bus.i_srcA;
          is_div_d = is_div_op;
          neg_q_d  = sign_a ^ sign_b;
          neg_r_d  = sign_a;
          cnt_d    = CNT_LOAD;
          acc_d    = is_div_op ? {{WIDTH{1'b0}}, cond_neg(bus.i_srcA, sign_a)}
                               : {{WIDTH{1'b0}}, cond_neg(bus.i_srcB, sign_b)};
        end
      end
      S_ITER: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (bmag_q == '0) begin
          hi_d = orig_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: ;
    endcase
  end

  assign bus.o_busy    = (state_q != S_IDLE);
  assign bus.o_stall   = bus.o_busy & (bus.i_start | bus.i_rd_hilo);
  assign bus.o_done    = done_q;
  assign bus.o_rd_data = bus.i_rd_sel ? hi_q : lo_q;

endmodule
